// File: rtl/lopd_norm_pipe_if.sv
// Handshake and data bundle for lopd_norm_pipe.
//   master : upstream/downstream side (drives i_valid/i_data/i_tag/i_ready)
//   slave  : the detector (drives o_ready and the registered result)
// POS_W follows DATA_W and is not meant to be overridden.
interface lopd_norm_pipe_if #(
    parameter int DATA_W = 24,
    parameter int TAG_W  = 4
);
    localparam int POS_W = $clog2(DATA_W);

    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic [TAG_W-1:0]  i_tag;
    logic              o_valid;
    logic              i_ready;
    logic [POS_W-1:0]  o_pos_one;
    logic [POS_W-1:0]  o_shift;
    logic [DATA_W-1:0] o_norm;
    logic              o_zero_flag;
    logic [TAG_W-1:0]  o_tag;

    modport master (
        output i_valid, i_data, i_tag, i_ready,
        input  o_ready, o_valid, o_pos_one, o_shift, o_norm, o_zero_flag, o_tag
    );

    modport slave (
        input  i_valid, i_data, i_tag, i_ready,
        output o_ready, o_valid, o_pos_one, o_shift, o_norm, o_zero_flag, o_tag
    );
endinterface

// File: rtl/lopd_norm_pipe.sv
// Two-stage leading-one position detector with normalising left shift.
// S1 registers the operand, tag, and a per-byte LOPD position plus zero flag.
// S2 picks the highest non-zero byte, forms pos/shift/norm and registers them.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset
//   bus      slave side of lopd_norm_pipe_if (valid/ready in, result out)
module lopd_norm_pipe #(
    parameter int DATA_W = 24,
    parameter int TAG_W  = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    lopd_norm_pipe_if.slave bus
);
    localparam int POS_W = $clog2(DATA_W);
    localparam int NG    = (DATA_W + 7) / 8;
    localparam int PAD_W = NG * 8;

    // S1 state
    logic                r_s1_valid;
    logic [DATA_W-1:0]   r_s1_data;
    logic [TAG_W-1:0]    r_s1_tag;
    logic [NG-1:0][2:0]  r_s1_gpos;
    logic [NG-1:0]       r_s1_gzero;

    // S2 (output) state
    logic                r_o_valid;
    logic [POS_W-1:0]    r_pos;
    logic [POS_W-1:0]    r_shift;
    logic [DATA_W-1:0]   r_norm;
    logic                r_zero;
    logic [TAG_W-1:0]    r_tag;

    logic [PAD_W-1:0]    w_pad;
    logic [NG-1:0][2:0]  w_gpos;
    logic [NG-1:0]       w_gzero;
    logic                w_s1_ready;
    logic                w_s2_ready;
    logic [POS_W-1:0]    w_pos;
    logic [POS_W-1:0]    w_shift;
    logic [DATA_W-1:0]   w_norm;
    logic                w_zero;

    // Zero pad on the MSB side so pad bits can never win the priority search.
    assign w_pad = PAD_W'(bus.i_data);

    // Per-byte priority encoders; the later (higher) bit overwrites lower ones.
    always_comb begin
        w_gpos  = '0;
        w_gzero = '0;
        for (int g = 0; g < NG; g++) begin
            w_gzero[g] = ~|w_pad[g*8 +: 8];
            for (int b = 0; b < 8; b++)
                if (w_pad[g*8+b]) w_gpos[g] = 3'(b);
        end
    end

    // Highest non-zero byte wins: pos = group_idx*8 + group_pos.
    always_comb begin
        w_pos = '0;
        for (int g = 0; g < NG; g++)
            if (!r_s1_gzero[g]) w_pos = POS_W'(g * 8 + int'(r_s1_gpos[g]));
        w_zero  = &r_s1_gzero;
        w_shift = w_zero ? '0 : POS_W'(DATA_W - 1) - w_pos;
        w_norm  = w_zero ? '0 : r_s1_data << w_shift;
    end

    // A stage loads when empty or when its contents leave this cycle.
    assign w_s2_ready = ~r_o_valid | bus.i_ready;
    assign w_s1_ready = ~r_s1_valid | w_s2_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_tag   <= '0;
            r_s1_gpos  <= '0;
            r_s1_gzero <= '0;
            r_o_valid  <= 1'b0;
            r_pos      <= '0;
            r_shift    <= '0;
            r_norm     <= '0;
            r_zero     <= 1'b0;
            r_tag      <= '0;
        end else begin
            if (w_s1_ready) begin
                r_s1_valid <= bus.i_valid;
                if (bus.i_valid) begin
                    r_s1_data  <= bus.i_data;
                    r_s1_tag   <= bus.i_tag;
                    r_s1_gpos  <= w_gpos;
                    r_s1_gzero <= w_gzero;
                end
            end
            if (w_s2_ready) begin
                r_o_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_pos   <= w_pos;
                    r_shift <= w_shift;
                    r_norm  <= w_norm;
                    r_zero  <= w_zero;
                    r_tag   <= r_s1_tag;
                end
            end
        end
    end

    assign bus.o_ready     = w_s1_ready;
    assign bus.o_valid     = r_o_valid;
    assign bus.o_pos_one   = r_pos;
    assign bus.o_shift     = r_shift;
    assign bus.o_norm      = r_norm;
    assign bus.o_zero_flag = r_zero;
    assign bus.o_tag       = r_tag;
endmodule

// File: tb/tb_lopd_norm_pipe.sv
module tb_lopd_norm_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lopd_norm_pipe_if #(.DATA_W(24), .TAG_W(4)) bus ();
    lopd_norm_pipe_if #(.DATA_W(17), .TAG_W(4)) b17 ();

    lopd_norm_pipe #(.DATA_W(24), .TAG_W(4)) u_dut   (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    lopd_norm_pipe #(.DATA_W(17), .TAG_W(4)) u_dut17 (.i_clk(clk), .i_rst_n(rst_n), .bus(b17));

    // {pos, shift, norm, zero, tag}
    logic [38:0] obs;
    logic [31:0] obs17;
    assign obs   = {bus.o_pos_one, bus.o_shift, bus.o_norm, bus.o_zero_flag, bus.o_tag};
    assign obs17 = {b17.o_pos_one, b17.o_shift, b17.o_norm, b17.o_zero_flag, b17.o_tag};

    // Reference: plain priority search over the operand, then a left shift.
    function automatic logic [38:0] ref24(input logic [23:0] d, input logic [3:0] t);
        int          p = 0;
        int          sh;
        logic        z;
        logic [23:0] n;
        z = (d == 24'd0);
        for (int i = 0; i < 24; i++) if (d[i]) p = i;
        sh = z ? 0 : 23 - p;
        n  = d << sh;
        return {5'(p), 5'(sh), n, z, t};
    endfunction

    function automatic logic [23:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 24'd0;
            1:       return 24'd1 << $urandom_range(0, 23);
            2:       return 24'($urandom);
            default: return 24'($urandom) >> $urandom_range(0, 23);
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_data = '0; bus.i_tag = '0; bus.i_ready = 1'b1;
        b17.i_valid = 1'b0; b17.i_data = '0; b17.i_tag = '0; b17.i_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
        n_cmp++;
        if (obs !== 39'd0) begin n_err++; $display("FAIL reset_outputs got %h want 0", obs); end
        n_cmp++;
        if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.o_ready); end
        n_cmp++;
        if (obs17 !== 32'd0) begin n_err++; $display("FAIL reset_outputs17 got %h want 0", obs17); end
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_data = 24'h000001; bus.i_tag = 4'd3; bus.i_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %b want 1", bus.o_ready); end
        @(negedge clk);
        bus.i_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL single_early got valid %b want 0", bus.o_valid); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL single_latency got valid %b want 1", bus.o_valid); end
        n_cmp++;
        if (obs !== {5'd0, 5'd23, 24'h800000, 1'b0, 4'd3})
            begin n_err++; $display("FAIL single_result got %h want %h", obs, {5'd0, 5'd23, 24'h800000, 1'b0, 4'd3}); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] din [3];
        logic [38:0] exp [3];
        din[0] = 24'h00F000; din[1] = 24'h800000; din[2] = 24'h000000;
        exp[0] = {5'd15, 5'd8, 24'hF00000, 1'b0, 4'd1};
        exp[1] = {5'd23, 5'd0, 24'h800000, 1'b0, 4'd2};
        exp[2] = {5'd0,  5'd0, 24'h000000, 1'b1, 4'd3};
        bus.i_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.i_valid = (c < 3);
            if (c < 3) begin bus.i_data = din[c]; bus.i_tag = 4'(c + 1); end
            #1;
            if (c >= 2) begin
                n_cmp++;
                if (bus.o_valid !== 1'b1 || obs !== exp[c-2]) begin
                    n_err++;
                    $display("FAIL b2b_result%0d got v=%b %h want v=1 %h", c - 2, bus.o_valid, obs, exp[c-2]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [23:0] din [4];
        logic [38:0] q[$];
        int sent = 0, got = 0, cyc = 0;
        bit seen_full = 0;
        for (int i = 0; i < 4; i++) din[i] = rnd_op() | 24'h1;
        while ((sent < 4 || q.size() != 0) && cyc < 40) begin
            @(negedge clk);
            bus.i_valid = (sent < 4);
            if (sent < 4) begin bus.i_data = din[sent]; bus.i_tag = 4'(8 + sent); end
            bus.i_ready = (cyc >= 6);
            #1;
            if (!bus.i_ready && sent >= 2) begin
                seen_full = 1;
                n_cmp++;
                if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready got %b want 0", bus.o_ready); end
            end
            if (bus.o_valid) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL stall_spurious got %h want none", obs); end
                else if (obs !== q[0]) begin n_err++; $display("FAIL stall_result got %h want %h", obs, q[0]); end
                if (bus.i_ready && q.size() != 0) begin void'(q.pop_front()); got++; end
            end
            if (bus.i_valid && bus.o_ready) begin q.push_back(ref24(din[sent], 4'(8 + sent))); sent++; end
            cyc++;
        end
        n_cmp++;
        if (got != 4 || !seen_full) begin n_err++; $display("FAIL stall_count got %0d want 4 (full seen %0d)", got, seen_full); end
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [38:0] q[$];
        logic [23:0] d;
        logic [3:0]  t;
        int sent = 0, got = 0, cyc = 0;
        d = rnd_op(); t = 4'($urandom);
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            bus.i_valid = (sent < 1000) && ($urandom_range(0, 9) < 7);
            bus.i_data  = d;
            bus.i_tag   = t;
            bus.i_ready = ($urandom_range(0, 9) < 6);
            #1;
            if (bus.o_valid) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL rand_spurious got %h want none", obs); end
                else if (obs !== q[0]) begin n_err++; $display("FAIL rand_result got %h want %h", obs, q[0]); end
                if (bus.i_ready && q.size() != 0) begin void'(q.pop_front()); got++; end
            end
            if (bus.i_valid && bus.o_ready) begin
                q.push_back(ref24(d, t));
                sent++;
                d = rnd_op(); t = 4'($urandom);
            end
            cyc++;
        end
        n_cmp++;
        if (got != 1000) begin n_err++; $display("FAIL rand_count got %0d want 1000", got); end
        @(negedge clk);
        bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    endtask

    task automatic test_odd_width();
        @(negedge clk);
        b17.i_valid = 1'b1; b17.i_data = 17'h10000; b17.i_tag = 4'd5; b17.i_ready = 1'b1;
        @(negedge clk);
        b17.i_data = 17'h00100; b17.i_tag = 4'd6;
        @(negedge clk);
        b17.i_valid = 1'b0;
        #1;
        n_cmp++;
        if (b17.o_valid !== 1'b1 || obs17 !== {5'd16, 5'd0, 17'h10000, 1'b0, 4'd5})
            begin n_err++; $display("FAIL w17_msb got v=%b %h want v=1 %h", b17.o_valid, obs17, {5'd16, 5'd0, 17'h10000, 1'b0, 4'd5}); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (b17.o_valid !== 1'b1 || obs17 !== {5'd8, 5'd8, 17'h10000, 1'b0, 4'd6})
            begin n_err++; $display("FAIL w17_mid got v=%b %h want v=1 %h", b17.o_valid, obs17, {5'd8, 5'd8, 17'h10000, 1'b0, 4'd6}); end
    endtask

    task automatic test_reset_inflight();
        int cyc = 0;
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1; bus.i_data = 24'h00ABCD; bus.i_tag = 4'hA;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (bus.o_ready && cyc < 10);
        n_cmp++;
        if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL rst_fill got ready %b want 0", bus.o_ready); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_valid !== 1'b0 || obs !== 39'd0 || bus.o_ready !== 1'b1)
            begin n_err++; $display("FAIL rst_flush got v=%b r=%b %h want v=0 r=1 0", bus.o_valid, bus.o_ready, obs); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL rst_ghost got valid %b want 0", bus.o_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_random();
        test_odd_width();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
